uu_wlan_tx_fifo_ctrl: RTL and testbench

//  Single-clock, parametrised MAC->PHY TX buffer/sequencer. Sits between LMAC TX path and PHY-SAP.

---
 rtl/uu_wlan_tx_fifo_pkg.sv | 21 ++
 rtl/uu_wlan_sync_fifo.sv | 72 +++++++
 rtl/uu_wlan_tx_fifo_ctrl.sv | 164 ++++++++++++++++
 tb/tb_uu_wlan_tx_fifo_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uu_wlan_tx_fifo_pkg.sv
// rtl/uu_wlan_tx_fifo_pkg.sv - shared state encoding, reset values and sizing helper for the TX FIFO controller
package uu_wlan_tx_fifo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VEC   = 3'd1,
        ST_START = 3'd2,
        ST_DATA  = 3'd3,
        ST_DRAIN = 3'd4,
        ST_END   = 3'd5
    } tx_state_e;

    localparam tx_state_e RST_STATE = ST_IDLE;
    localparam logic      RST_FLAG  = 1'b0;

    // Occupancy needs one extra bit so that a completely full buffer is representable.
    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/uu_wlan_sync_fifo.sv
// rtl/uu_wlan_sync_fifo.sv - single-clock buffer with exact occupancy, zero-latency head and synchronous flush
module uu_wlan_sync_fifo
    import uu_wlan_tx_fifo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        wr_en,
    input  logic [DATA_W-1:0]           wr_data,
    input  logic                        rd_en,
    output logic [DATA_W-1:0]           rd_data,
    output logic [level_w(DEPTH)-1:0]   level,
    output logic                        full,
    output logic                        empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = level_w(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              do_wr, do_rd;

    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    always_comb begin
        do_wr    = wr_en && !full && !flush;
        do_rd    = rd_en && !empty && !flush;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; the head is only meaningful while not empty.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/uu_wlan_tx_fifo_ctrl.sv
// rtl/uu_wlan_tx_fifo_ctrl.sv - MAC->PHY TX sequencer: buffers TXVECTOR and PSDU, drives TXSTART/TXDATA/TXEND handshakes
module uu_wlan_tx_fifo_ctrl
    import uu_wlan_tx_fifo_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 64,
    parameter int TXVEC_LEN = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic                        mac2fifo_txstart_req,
    input  logic                        mac2fifo_frame_val,
    input  logic [DATA_W-1:0]           mac2fifo_phy_frame,
    input  logic                        mac2fifo_txend_req,
    output logic                        fifo2mac_txstart_confirm,
    output logic                        fifo2mac_txdata_confirm,
    output logic                        fifo2mac_txend_confirm,
    output logic                        fifo2phy_txstart_req,
    output logic                        fifo2phy_frame_val,
    output logic [DATA_W-1:0]           fifo2phy_phy_frame,
    output logic                        fifo2phy_txend_req,
    input  logic                        phy2fifo_txstart_confirm,
    input  logic                        phy2fifo_txdata_confirm,
    input  logic                        phy2fifo_txend_confirm,
    output logic [level_w(DEPTH)-1:0]   fifo_level,
    output logic                        overflow_err,
    output logic                        underrun_err
);

    localparam int VEC_W = (TXVEC_LEN > 1) ? $clog2(TXVEC_LEN) : 1;
    localparam int LVL_W = level_w(DEPTH);

    tx_state_e         state_q, state_d;
    logic [VEC_W-1:0]  vec_cnt_q, vec_cnt_d;
    logic              start_cf_seen_q, start_cf_seen_d;
    logic              start_pulse_q, start_pulse_d;
    logic              end_pulse_q, end_pulse_d;
    logic              ovf_q, ovf_d;
    logic              unr_q, unr_d;
    logic              start_cf_now;
    logic              push, pop, flush, out_val;
    logic              full, empty;
    logic [DATA_W-1:0] head_data;
    logic [LVL_W-1:0]  level;

    uu_wlan_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .wr_en   (push),
        .wr_data (mac2fifo_phy_frame),
        .rd_en   (pop),
        .rd_data (head_data),
        .level   (level),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_d         = state_q;
        vec_cnt_d       = vec_cnt_q;
        start_cf_seen_d = start_cf_seen_q;
        start_pulse_d   = 1'b0;
        end_pulse_d     = 1'b0;
        ovf_d           = ovf_q;
        unr_d           = unr_q;
        start_cf_now    = start_cf_seen_q || phy2fifo_txstart_confirm;
        push            = 1'b0;
        flush           = 1'b0;
        out_val         = (state_q inside {ST_START, ST_DATA, ST_DRAIN}) && !empty;
        pop             = out_val && phy2fifo_txdata_confirm;

        fifo2phy_txstart_req    = (state_q == ST_START) && !start_cf_seen_q;
        fifo2phy_txend_req      = (state_q == ST_END);
        fifo2mac_txdata_confirm = (state_q == ST_DATA) && !full;

        // Disable aborts the frame from any state; error flags deliberately survive it.
        if (!enable) begin
            state_d         = ST_IDLE;
            vec_cnt_d       = '0;
            start_cf_seen_d = 1'b0;
            flush           = 1'b1;
            pop             = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mac2fifo_txstart_req) begin
                        state_d   = ST_VEC;
                        vec_cnt_d = '0;
                        ovf_d     = 1'b0;
                        unr_d     = 1'b0;
                    end
                end
                ST_VEC: begin
                    if (mac2fifo_frame_val) begin
                        push      = 1'b1;
                        vec_cnt_d = vec_cnt_q + 1'b1;
                        if (vec_cnt_q == VEC_W'(TXVEC_LEN - 1)) begin
                            state_d         = ST_START;
                            start_cf_seen_d = 1'b0;
                        end
                    end
                end
                ST_START: begin
                    start_cf_seen_d = start_cf_now;
                    if (start_cf_now && empty) begin
                        state_d         = ST_DATA;
                        start_pulse_d   = 1'b1;
                        start_cf_seen_d = 1'b0;
                    end
                end
                ST_DATA: begin
                    push = mac2fifo_frame_val && !full;
                    if (mac2fifo_frame_val && full) ovf_d = 1'b1;
                    if (empty && phy2fifo_txdata_confirm) unr_d = 1'b1;
                    if (mac2fifo_txend_req) state_d = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (empty) state_d = ST_END;
                end
                ST_END: begin
                    if (phy2fifo_txend_confirm) begin
                        state_d     = ST_IDLE;
                        end_pulse_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= RST_STATE;
            vec_cnt_q       <= '0;
            start_cf_seen_q <= RST_FLAG;
            start_pulse_q   <= RST_FLAG;
            end_pulse_q     <= RST_FLAG;
            ovf_q           <= RST_FLAG;
            unr_q           <= RST_FLAG;
        end else begin
            state_q         <= state_d;
            vec_cnt_q       <= vec_cnt_d;
            start_cf_seen_q <= start_cf_seen_d;
            start_pulse_q   <= start_pulse_d;
            end_pulse_q     <= end_pulse_d;
            ovf_q           <= ovf_d;
            unr_q           <= unr_d;
        end
    end

    assign fifo2mac_txstart_confirm = start_pulse_q;
    assign fifo2mac_txend_confirm   = end_pulse_q;
    assign fifo2phy_frame_val       = out_val;
    assign fifo2phy_phy_frame       = out_val ? head_data : '0;
    assign fifo_level               = level;
    assign overflow_err             = ovf_q;
    assign underrun_err             = unr_q;

endmodule

// File: tb/tb_uu_wlan_tx_fifo_ctrl.sv
// tb/tb_uu_wlan_tx_fifo_ctrl.sv - randomized frame-level bench with a queue-based reference model
module tb_uu_wlan_tx_fifo_ctrl;

    localparam int DATA_W    = 8;
    localparam int DEPTH     = 32;
    localparam int TXVEC_LEN = 32;
    localparam int LVL_W     = $clog2(DEPTH) + 1;
    localparam int P_IDLE = 0, P_VEC = 1, P_START = 2, P_DATA = 3, P_DRAIN = 4, P_END = 5;

    logic              clk = 1'b0;
    logic              rst_n, enable;
    logic              mac2fifo_txstart_req, mac2fifo_frame_val, mac2fifo_txend_req;
    logic [DATA_W-1:0] mac2fifo_phy_frame;
    logic              fifo2mac_txstart_confirm, fifo2mac_txdata_confirm, fifo2mac_txend_confirm;
    logic              fifo2phy_txstart_req, fifo2phy_frame_val, fifo2phy_txend_req;
    logic [DATA_W-1:0] fifo2phy_phy_frame;
    logic              phy2fifo_txstart_confirm, phy2fifo_txdata_confirm, phy2fifo_txend_confirm;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow_err, underrun_err;

    always #5 clk = ~clk;

    uu_wlan_tx_fifo_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TXVEC_LEN(TXVEC_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .mac2fifo_txstart_req(mac2fifo_txstart_req), .mac2fifo_frame_val(mac2fifo_frame_val),
        .mac2fifo_phy_frame(mac2fifo_phy_frame), .mac2fifo_txend_req(mac2fifo_txend_req),
        .fifo2mac_txstart_confirm(fifo2mac_txstart_confirm),
        .fifo2mac_txdata_confirm(fifo2mac_txdata_confirm),
        .fifo2mac_txend_confirm(fifo2mac_txend_confirm),
        .fifo2phy_txstart_req(fifo2phy_txstart_req), .fifo2phy_frame_val(fifo2phy_frame_val),
        .fifo2phy_phy_frame(fifo2phy_phy_frame), .fifo2phy_txend_req(fifo2phy_txend_req),
        .phy2fifo_txstart_confirm(phy2fifo_txstart_confirm),
        .phy2fifo_txdata_confirm(phy2fifo_txdata_confirm),
        .phy2fifo_txend_confirm(phy2fifo_txend_confirm),
        .fifo_level(fifo_level), .overflow_err(overflow_err), .underrun_err(underrun_err)
    );

    int total = 0, bad = 0;
    int mode, cyc, max_level, popped;
    int phase, vec_n;
    logic [DATA_W-1:0] mq[$];
    bit cf_seen, exp_spulse, exp_epulse, exp_ovf, exp_unr;
    bit last_acc, seen_scf, seen_ecf, seen_ereq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        phase = P_IDLE; vec_n = 0; mq.delete();
        cf_seen = 0; exp_spulse = 0; exp_epulse = 0; exp_ovf = 0; exp_unr = 0;
    endtask

    // One clock: check outputs against the model at negedge, then advance the model to the next edge.
    task automatic cycle();
        bit exp_val, pop, acc, n_sp, n_ep;
        case (mode)
            0:       phy2fifo_txdata_confirm = 1'b1;
            1:       phy2fifo_txdata_confirm = 1'($urandom_range(0, 1));
            2:       phy2fifo_txdata_confirm = ((cyc % 18) >= 11);
            default: phy2fifo_txdata_confirm = 1'b0;
        endcase
        @(negedge clk);
        exp_val = (phase == P_START || phase == P_DATA || phase == P_DRAIN) && mq.size() != 0;
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("frame_val", 32'(fifo2phy_frame_val), 32'(exp_val));
        if (exp_val && phy2fifo_txdata_confirm) chk("phy_frame", 32'(fifo2phy_phy_frame), 32'(mq[0]));
        chk("txstart_req", 32'(fifo2phy_txstart_req), 32'(phase == P_START && !cf_seen));
        chk("txdata_confirm", 32'(fifo2mac_txdata_confirm), 32'(phase == P_DATA && mq.size() < DEPTH));
        chk("txend_req", 32'(fifo2phy_txend_req), 32'(phase == P_END));
        chk("txstart_confirm", 32'(fifo2mac_txstart_confirm), 32'(exp_spulse));
        chk("txend_confirm", 32'(fifo2mac_txend_confirm), 32'(exp_epulse));
        chk("overflow_err", 32'(overflow_err), 32'(exp_ovf));
        chk("underrun_err", 32'(underrun_err), 32'(exp_unr));
        if (fifo2mac_txstart_confirm === 1'b1) seen_scf = 1;
        if (fifo2mac_txend_confirm === 1'b1) seen_ecf = 1;
        if (fifo2phy_txend_req === 1'b1) seen_ereq = 1;
        if (fifo2phy_frame_val === 1'b1 && phy2fifo_txdata_confirm) popped++;
        if (int'(fifo_level) > max_level) max_level = int'(fifo_level);

        pop = exp_val && phy2fifo_txdata_confirm; acc = 0; n_sp = 0; n_ep = 0;
        if (!rst_n) model_reset();
        else if (!enable) begin
            phase = P_IDLE; mq.delete(); cf_seen = 0; exp_spulse = 0; exp_epulse = 0;
        end else begin
            if (mac2fifo_frame_val && (phase == P_VEC || phase == P_DATA)) begin
                acc = mq.size() < DEPTH;
                if (!acc && phase == P_DATA) exp_ovf = 1;
            end
            if (phase == P_DATA && mq.size() == 0 && phy2fifo_txdata_confirm) exp_unr = 1;
            case (phase)
                P_IDLE: if (mac2fifo_txstart_req) begin
                    phase = P_VEC; vec_n = 0; exp_ovf = 0; exp_unr = 0;
                end
                P_VEC: if (mac2fifo_frame_val) begin
                    vec_n++;
                    if (vec_n == TXVEC_LEN) begin phase = P_START; cf_seen = 0; end
                end
                P_START: begin
                    cf_seen = cf_seen || phy2fifo_txstart_confirm;
                    if (cf_seen && mq.size() == 0) begin phase = P_DATA; n_sp = 1; cf_seen = 0; end
                end
                P_DATA:  if (mac2fifo_txend_req) phase = P_DRAIN;
                P_DRAIN: if (mq.size() == 0) phase = P_END;
                default: if (phy2fifo_txend_confirm) begin phase = P_IDLE; n_ep = 1; end
            endcase
            if (pop) void'(mq.pop_front());
            if (acc) mq.push_back(mac2fifo_phy_frame);
            exp_spulse = n_sp; exp_epulse = n_ep;
        end
        last_acc = acc;
        @(posedge clk); #1;
        cyc++;
        mac2fifo_txstart_req = 0; mac2fifo_frame_val = 0; mac2fifo_txend_req = 0;
        phy2fifo_txstart_confirm = 0; phy2fifo_txend_confirm = 0;
    endtask

    task automatic issue_txstart();
        popped = 0; max_level = 0;
        mac2fifo_txstart_req = 1; cycle();
    endtask

    task automatic push_vector();
        int cnt;
        cnt = 0;
        for (int g = 0; g < 400 && cnt < TXVEC_LEN; g++) begin
            mac2fifo_frame_val = ($urandom_range(0, 3) != 0);
            mac2fifo_phy_frame = DATA_W'($urandom);
            cycle();
            if (last_acc) cnt++;
        end
        chk("vector_pushed", 32'(cnt), 32'(TXVEC_LEN));
    endtask

    task automatic wait_data();
        int d;
        d = $urandom_range(0, 40);
        seen_scf = 0;
        for (int c = 0; c < 600 && !seen_scf; c++) begin
            if (c == d) phy2fifo_txstart_confirm = 1;
            cycle();
        end
        chk("txstart_cf_seen", 32'(seen_scf), 32'd1);
    endtask

    task automatic push_data(input int n, input bit force_push, input int gap, input bit do_end);
        int cnt;
        bit same_end, ended, e;
        cnt = 0; ended = 0;
        same_end = 1'($urandom_range(0, 1)) && !force_push;
        repeat (gap) cycle();
        for (int g = 0; g < 3000 && cnt < n; g++) begin
            mac2fifo_frame_val = force_push ? 1'b1 : (fifo2mac_txdata_confirm && ($urandom_range(0, 3) != 0));
            mac2fifo_phy_frame = DATA_W'($urandom);
            e = do_end && same_end && mac2fifo_frame_val && (cnt == n - 1);
            mac2fifo_txend_req = e;
            cycle();
            if (force_push || last_acc) cnt++;
            if (e) ended = 1;
        end
        chk("data_pushed", 32'(cnt), 32'(n));
        if (do_end && !ended) begin mac2fifo_txend_req = 1; cycle(); end
    endtask

    task automatic finish_frame();
        seen_ereq = 0;
        for (int c = 0; c < 3000 && !seen_ereq; c++) cycle();
        chk("txend_req_seen", 32'(seen_ereq), 32'd1);
        repeat ($urandom_range(0, 3)) cycle();
        phy2fifo_txend_confirm = 1;
        seen_ecf = 0;
        cycle();
        for (int c = 0; c < 4 && !seen_ecf; c++) cycle();
        chk("txend_cf_seen", 32'(seen_ecf), 32'd1);
    endtask

    task automatic run_frame(input int n, input int gap);
        issue_txstart(); push_vector(); wait_data();
        push_data(n, 1'b0, gap, 1'b1); finish_frame();
        chk("frame_beats", 32'(popped), 32'(TXVEC_LEN + n));
    endtask

    initial begin
        rst_n = 0; enable = 1; mode = 0; cyc = 0; popped = 0; max_level = 0;
        mac2fifo_txstart_req = 0; mac2fifo_frame_val = 0; mac2fifo_txend_req = 0;
        mac2fifo_phy_frame = '0; phy2fifo_txstart_confirm = 0; phy2fifo_txdata_confirm = 0;
        phy2fifo_txend_confirm = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst_n = 1;
        chk("rst_phy_frame", 32'(fifo2phy_phy_frame), 32'd0);

        // Plain frame, PHY always ready.
        mode = 0; run_frame(7, 0);

        // Bursty PHY: buffer must fill exactly to DEPTH with no loss and no overflow.
        mode = 2; run_frame(80, 0);
        chk("t3_max_level", 32'(max_level), 32'(DEPTH));
        chk("t3_no_overflow", 32'(overflow_err), 32'd0);

        // Forced pushes into a stalled, full buffer.
        mode = 0; issue_txstart(); push_vector(); wait_data();
        mode = 3; push_data(DEPTH + 5, 1'b1, 0, 1'b1);
        mode = 0; finish_frame();
        chk("t4_overflow", 32'(overflow_err), 32'd1);
        chk("t4_beats", 32'(popped), 32'(TXVEC_LEN + DEPTH));

        // Ready PHY with an idle MAC in DATA, then the next frame start clears the flag.
        mode = 1; run_frame(5, 20);
        chk("t5_underrun", 32'(underrun_err), 32'd1);
        mode = 0; issue_txstart();
        chk("t5_underrun_clr", 32'(underrun_err), 32'd0);
        chk("t5_overflow_clr", 32'(overflow_err), 32'd0);

        // Same frame continues into DATA; reset hits with 10 beats buffered.
        push_vector(); wait_data();
        mode = 3; push_data(10, 1'b0, 0, 1'b0);
        chk("t1_level_before", 32'(fifo_level), 32'd10);
        rst_n = 0; cycle(); rst_n = 1;
        chk("t1_level", 32'(fifo_level), 32'd0);
        chk("t1_frame_val", 32'(fifo2phy_frame_val), 32'd0);
        chk("t1_phy_frame", 32'(fifo2phy_phy_frame), 32'd0);
        chk("t1_txdata_cf", 32'(fifo2mac_txdata_confirm), 32'd0);
        chk("t1_errs", 32'({overflow_err, underrun_err}), 32'd0);
        mode = 0; cycle();

        // Abort in START, then a clean frame.
        issue_txstart(); push_vector();
        repeat (3) cycle();
        enable = 0; cycle(); enable = 1;
        chk("t6_level", 32'(fifo_level), 32'd0);
        chk("t6_txstart_req", 32'(fifo2phy_txstart_req), 32'd0);
        chk("t6_frame_val", 32'(fifo2phy_frame_val), 32'd0);
        mode = 1; run_frame(7, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
